// File: rtl/generic_fifo_sc_prog_if.sv
// rtl/generic_fifo_sc_prog_if.sv - request/status bundle for the single-clock programmable FIFO
interface generic_fifo_sc_prog_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          clr;
    logic [DW-1:0] din;
    logic          we;
    logic          re;
    logic [AW:0]   af_thr;
    logic [AW:0]   ae_thr;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          full_n;
    logic          empty_n;
    logic [AW:0]   cnt;
    logic [1:0]    level;
    logic          ovf;
    logic          udf;

    modport master (
        output clr, din, we, re, af_thr, ae_thr,
        input  dout, full, empty, full_n, empty_n, cnt, level, ovf, udf
    );

    modport slave (
        input  clr, din, we, re, af_thr, ae_thr,
        output dout, full, empty, full_n, empty_n, cnt, level, ovf, udf
    );
endinterface

// File: rtl/generic_fifo_sc_prog.sv
// rtl/generic_fifo_sc_prog.sv - single-clock FIFO with programmable almost-full/almost-empty and sticky errors
module generic_fifo_sc_prog #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int FWFT = 0
) (
    input logic                    clk,
    input logic                    rst,
    generic_fifo_sc_prog_if.slave  f
);
    localparam int          D     = 1 << AW;
    localparam logic [AW:0] D_CNT = (AW+1)'(D);
    localparam logic [AW:0] Q1    = (AW+1)'(D / 4);
    localparam logic [AW:0] Q2    = (AW+1)'(D / 2);
    localparam logic [AW:0] Q3    = (AW+1)'((3 * D) / 4);

    logic [DW-1:0] mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic [DW-1:0] dout_q;
    logic          ovf_q;
    logic          udf_q;
    logic          full_i;
    logic          empty_i;
    logic          wr_ok;
    logic          rd_ok;

    // Flags come only from the registered count; pointers carry no wrap bit.
    assign full_i  = (cnt_q == D_CNT);
    assign empty_i = (cnt_q == '0);
    assign wr_ok   = f.we & ~full_i & ~f.clr;
    assign rd_ok   = f.re & ~empty_i & ~f.clr;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= f.din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (f.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (f.we && full_i)  ovf_q <= 1'b1;
            if (f.re && empty_i) udf_q <= 1'b1;
            if (rd_ok)           dout_q <= mem[rd_ptr];
        end
    end

    // FWFT shows the head word combinationally; zero while nothing is held.
    generate
        if (FWFT != 0) begin : g_fwft
            assign f.dout = empty_i ? '0 : mem[rd_ptr];
        end else begin : g_std
            assign f.dout = dout_q;
        end
    endgenerate

    always_comb begin
        f.level = 2'd3;
        if (cnt_q < Q1)      f.level = 2'd0;
        else if (cnt_q < Q2) f.level = 2'd1;
        else if (cnt_q < Q3) f.level = 2'd2;
    end

    assign f.cnt     = cnt_q;
    assign f.full    = full_i;
    assign f.empty   = empty_i;
    assign f.full_n  = (cnt_q >= f.af_thr);
    assign f.empty_n = (cnt_q <= f.ae_thr);
    assign f.ovf     = ovf_q;
    assign f.udf     = udf_q;
endmodule

// File: tb/tb_generic_fifo_sc_prog.sv
// tb/tb_generic_fifo_sc_prog.sv - checks standard and FWFT FIFO builds against a queue model
module tb_generic_fifo_sc_prog;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    generic_fifo_sc_prog_if #(.DW(DW), .AW(AW)) bus_s ();
    generic_fifo_sc_prog_if #(.DW(DW), .AW(AW)) bus_f ();

    assign bus_f.clr    = bus_s.clr;
    assign bus_f.din    = bus_s.din;
    assign bus_f.we     = bus_s.we;
    assign bus_f.re     = bus_s.re;
    assign bus_f.af_thr = bus_s.af_thr;
    assign bus_f.ae_thr = bus_s.ae_thr;

    generic_fifo_sc_prog #(.DW(DW), .AW(AW), .FWFT(0)) u_std (.clk(clk), .rst(rst), .f(bus_s));
    generic_fifo_sc_prog #(.DW(DW), .AW(AW), .FWFT(1)) u_fwft (.clk(clk), .rst(rst), .f(bus_f));

    int n_vec = 0;
    int n_err = 0;
    int af = 12;
    int ae = 3;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_dout = 8'h00;

    typedef struct {
        logic       we, re, clr;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       fn, en;
        logic [1:0] lvl;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = 8'h00;
    endtask

    task automatic check_all();
        int n;
        int lv;
        n  = q.size();
        lv = (n * 4) / D;
        if (lv > 3) lv = 3;
        chk("cnt",     32'(bus_s.cnt),     32'(n));
        chk("full",    32'(bus_s.full),    32'(n == D));
        chk("empty",   32'(bus_s.empty),   32'(n == 0));
        chk("full_n",  32'(bus_s.full_n),  32'(n >= af));
        chk("empty_n", 32'(bus_s.empty_n), 32'(n <= ae));
        chk("level",   32'(bus_s.level),   32'(lv));
        chk("ovf",     32'(bus_s.ovf),     32'(m_ovf));
        chk("udf",     32'(bus_s.udf),     32'(m_udf));
        chk("dout",    32'(bus_s.dout),    32'(m_dout));
        chk("f_cnt",   32'(bus_f.cnt),     32'(n));
        chk("f_empty", 32'(bus_f.empty),   32'(n == 0));
        chk("f_ovf",   32'(bus_f.ovf),     32'(m_ovf));
        chk("f_udf",   32'(bus_f.udf),     32'(m_udf));
        if (n > 0) chk("f_dout", 32'(bus_f.dout), 32'(q[0]));
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        bool_drive: begin
            bus_s.we     = w;
            bus_s.re     = r;
            bus_s.clr    = c;
            bus_s.din    = d;
            bus_s.af_thr = 5'(af);
            bus_s.ae_thr = 5'(ae);
        end
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            bit was_full, was_empty;
            was_full  = (q.size() == D);
            was_empty = (q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full)  q.push_back(d);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 8'h20, 5'd1,  0, 1, 2'd0};
        tbl[1]  = '{1, 0, 0, 8'h21, 5'd2,  0, 1, 2'd0};
        tbl[2]  = '{1, 0, 0, 8'h22, 5'd3,  0, 1, 2'd0};
        tbl[3]  = '{1, 0, 0, 8'h23, 5'd4,  0, 0, 2'd1};
        tbl[4]  = '{1, 1, 0, 8'h24, 5'd4,  0, 0, 2'd1};
        tbl[5]  = '{0, 1, 0, 8'h25, 5'd3,  0, 1, 2'd0};
        tbl[6]  = '{1, 0, 0, 8'h26, 5'd4,  0, 0, 2'd1};
        tbl[7]  = '{1, 0, 0, 8'h27, 5'd5,  0, 0, 2'd1};
        tbl[8]  = '{1, 0, 0, 8'h28, 5'd6,  0, 0, 2'd1};
        tbl[9]  = '{1, 0, 0, 8'h29, 5'd7,  0, 0, 2'd1};
        tbl[10] = '{1, 0, 0, 8'h2a, 5'd8,  0, 0, 2'd2};
        tbl[11] = '{1, 0, 0, 8'h2b, 5'd9,  0, 0, 2'd2};
        tbl[12] = '{1, 0, 0, 8'h2c, 5'd10, 0, 0, 2'd2};
        tbl[13] = '{1, 0, 0, 8'h2d, 5'd11, 0, 0, 2'd2};
        tbl[14] = '{1, 0, 0, 8'h2e, 5'd12, 1, 0, 2'd3};
        tbl[15] = '{0, 1, 0, 8'h2f, 5'd11, 0, 0, 2'd2};
        tbl[16] = '{0, 0, 1, 8'h30, 5'd0,  0, 1, 2'd0};

        bus_s.we = 0; bus_s.re = 0; bus_s.clr = 0; bus_s.din = '0;
        bus_s.af_thr = 5'(af); bus_s.ae_thr = 5'(ae);
        repeat (2) @(negedge clk);
        model_reset();
        check_all();
        rst = 1'b1;
        @(negedge clk);

        // Fill to full, then drain in order
        for (int i = 0; i < D; i++) step(1, 0, 0, 8'(i + 1));
        chk("t1_full", 32'(bus_s.full), 32'd1);
        chk("t1_level", 32'(bus_s.level), 32'd3);
        for (int i = 0; i < D; i++) begin
            step(0, 1, 0, 8'h00);
            chk("t1_dout", 32'(bus_s.dout), 32'(i + 1));
        end
        chk("t1_empty", 32'(bus_s.empty), 32'd1);

        // Overflow / underflow stickiness and clear
        for (int i = 0; i < D; i++) step(1, 0, 0, 8'(8'h40 + i));
        step(1, 0, 0, 8'hAA);
        chk("t2_ovf", 32'(bus_s.ovf), 32'd1);
        step(0, 0, 0, 8'h00);
        chk("t2_ovf_hold", 32'(bus_s.ovf), 32'd1);
        step(0, 0, 1, 8'h00);
        step(0, 1, 0, 8'h00);
        chk("t2_udf", 32'(bus_s.udf), 32'd1);
        step(0, 0, 1, 8'h00);
        chk("t2_clr", 32'({bus_s.ovf, bus_s.udf, bus_s.cnt}), 32'd0);

        // Steady state at cnt=8 across pointer wrap
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h60 + i));
        for (int i = 0; i < 20; i++) step(1, 1, 0, 8'($urandom));
        chk("t3_cnt", 32'(bus_s.cnt), 32'd8);
        step(0, 0, 1, 8'h00);

        // Threshold table, af=12 ae=3
        af = 12; ae = 3;
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].din);
            chk("tbl_cnt",     32'(bus_s.cnt),     32'(tbl[i].cnt));
            chk("tbl_full_n",  32'(bus_s.full_n),  32'(tbl[i].fn));
            chk("tbl_empty_n", 32'(bus_s.empty_n), 32'(tbl[i].en));
            chk("tbl_level",   32'(bus_s.level),   32'(tbl[i].lvl));
        end

        // Threshold extremes
        af = 0; ae = D;
        step(0, 0, 0, 8'h00);
        chk("thr0_full_n", 32'(bus_s.full_n), 32'd1);
        for (int i = 0; i < D; i++) step(1, 0, 0, 8'(i));
        chk("thrD_empty_n", 32'(bus_s.empty_n), 32'd1);
        step(0, 0, 1, 8'h00);
        af = 12; ae = 3;

        // FWFT head visibility
        step(1, 0, 0, 8'h5C);
        chk("t5_empty", 32'(bus_f.empty), 32'd0);
        chk("t5_dout", 32'(bus_f.dout), 32'h5C);
        step(0, 0, 0, 8'h00);
        chk("t5_dout_hold", 32'(bus_f.dout), 32'h5C);
        step(0, 1, 0, 8'h00);
        chk("t5_empty_after", 32'(bus_f.empty), 32'd1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 9; i++) step(1, 0, 0, 8'(8'h70 + i));
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_cnt", 32'(bus_s.cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h90 + i));
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            chk("t6_dout", 32'(bus_s.dout), 32'(8'h90 + i));
        end

        // Randomized traffic with changing thresholds and biased phases
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            if (i % 60 == 0) begin
                af = $urandom_range(0, D);
                ae = $urandom_range(0, D);
            end
            case ((i / 100) % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                 $urandom_range(0, 79) == 0, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
